// File: rtl/regfile_port_ctrl_if.sv
// Debug access channel into the register file controller.
// Handshake: the requester raises dbg_req with dbg_we/dbg_addr/dbg_wdata stable and holds it until
// a one-cycle dbg_ack; dbg_rdata is valid from the ack cycle on, and dbg_req is dropped in the ack cycle.
interface regfile_port_ctrl_if;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Register file write-port / RD2 arbiter: post-reset sweep of x1..x31, writeback pass-through,
// and debug read/write slotting that always yields to pipeline writeback.
module regfile_port_ctrl #(
  parameter bit          ENABLE_INIT = 1'b1,
  parameter logic [31:0] INIT_VAL    = 32'h0000_0000,
  parameter int          MAX_WAIT    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_port_ctrl_if.slave   dbg,
  input  logic                 wb_we,
  input  logic [4:0]           wb_addr,
  input  logic [31:0]          wb_data,
  output logic                 rf_we3,
  output logic [4:0]           rf_a3,
  output logic [31:0]          rf_wd3,
  output logic                 rf_a2_sel,
  output logic [4:0]           rf_a2_dbg,
  input  logic [31:0]          rf_rd2,
  output logic                 stall_o,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int WW = $clog2(MAX_WAIT + 1) + 1;

  // Encoding is visible on state_dbg: 0 INIT, 1 IDLE, 2 DBG_RD, 3 DBG_WR, 4 ACK.
  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_DBG_RD = 3'd2,
    S_DBG_WR = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [4:0]      cnt, cnt_next;
  logic [WW-1:0]   waitcnt, waitcnt_next;
  logic            ack_q;
  logic [31:0]     rdata_q;
  logic [31:0]     rd_sel;
  logic            wb_port_busy;

  assign wb_port_busy  = wb_we && (wb_addr != 5'd0);
  assign rf_a2_dbg     = dbg.dbg_addr;
  assign dbg.dbg_ack   = ack_q;
  assign dbg.dbg_rdata = rdata_q;
  assign state_dbg     = state;

  // A writeback landing on the same register this cycle is newer than RD2.
  always_comb begin
    rd_sel = rf_rd2;
    if (dbg.dbg_addr == 5'd0)
      rd_sel = 32'h0;
    else if (wb_we && (wb_addr == dbg.dbg_addr))
      rd_sel = wb_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ENABLE_INIT ? S_INIT : S_IDLE;
      cnt     <= 5'd1;
      waitcnt <= '0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      waitcnt <= waitcnt_next;
      ack_q   <= (state_next == S_ACK);
      if (state == S_DBG_RD)
        rdata_q <= rd_sel;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    waitcnt_next = waitcnt;
    rf_we3       = wb_port_busy;
    rf_a3        = wb_addr;
    rf_wd3       = wb_data;
    rf_a2_sel    = 1'b0;
    stall_o      = 1'b0;
    busy         = 1'b0;

    case (state)
      S_INIT: begin
        rf_we3   = 1'b1;
        rf_a3    = cnt;
        rf_wd3   = INIT_VAL;
        stall_o  = 1'b1;
        busy     = 1'b1;
        cnt_next = cnt + 5'd1;
        if (cnt == 5'd31)
          state_next = S_IDLE;
      end
      S_IDLE: begin
        if (dbg.dbg_req) begin
          state_next   = dbg.dbg_we ? S_DBG_WR : S_DBG_RD;
          waitcnt_next = '0;
        end
      end
      S_DBG_RD: begin
        stall_o    = 1'b1;
        rf_a2_sel  = 1'b1;
        state_next = S_ACK;
      end
      S_DBG_WR: begin
        // Past the wait budget, freeze the front so the pipeline drains and frees the port.
        stall_o = (waitcnt >= WW'(MAX_WAIT));
        if (wb_port_busy) begin
          if (waitcnt < WW'(MAX_WAIT))
            waitcnt_next = waitcnt + WW'(1);
        end else begin
          rf_we3     = (dbg.dbg_addr != 5'd0);
          rf_a3      = dbg.dbg_addr;
          rf_wd3     = dbg.dbg_wdata;
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (!rst) begin
      rf_we3    = 1'b0;
      rf_a2_sel = 1'b0;
      stall_o   = 1'b1;
      busy      = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural 32x32 register file on the write/RD2 ports.
module tb_regfile_port_ctrl;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_we3;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_a2_sel;
  logic [4:0]  rf_a2_dbg;
  logic [31:0] rf_rd2;
  logic        stall_o;
  logic        busy;
  logic [2:0]  state_dbg;

  logic [31:0] rf_m [32];

  int n_total;
  int n_bad;

  regfile_port_ctrl_if dbg_bus ();

  regfile_port_ctrl #(
    .ENABLE_INIT (1'b1),
    .INIT_VAL    (32'hDEAD_0000),
    .MAX_WAIT    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dbg       (dbg_bus),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rf_we3    (rf_we3),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .rf_a2_sel (rf_a2_sel),
    .rf_a2_dbg (rf_a2_dbg),
    .rf_rd2    (rf_rd2),
    .stall_o   (stall_o),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset-independent register file model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (rf_we3) rf_m[rf_a3] <= rf_wd3;
  end

  assign rf_rd2 = rf_m[rf_a2_sel ? rf_a2_dbg : 5'd0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Samples the sweep from the current point until busy falls (bounded).
  task automatic sweep_run(output int n, output int order_bad);
    int exp_a;
    n = 0;
    order_bad = 0;
    exp_a = 1;
    while (busy && n < 40) begin
      if (!rf_we3 || rf_a3 != 5'(exp_a) || rf_wd3 != 32'hDEAD_0000) order_bad++;
      exp_a++;
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  // Caller is at a negedge in IDLE (cycle 0). Writeback is driven for cycles [wb_from, wb_from+wb_len).
  task automatic dbg_txn(
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  int          wb_from,
    input  int          wb_len,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output int          ack_cyc,
    output logic [31:0] rdata,
    output int          stall_n,
    output int          first_stall,
    output int          commit_cyc,
    output int          wb_hits,
    output int          dbg_pulses
  );
    int cyc;
    ack_cyc = -1; rdata = 32'h0; stall_n = 0; first_stall = -1;
    commit_cyc = -1; wb_hits = 0; dbg_pulses = 0;
    cyc = 0;
    dbg_bus.dbg_req   = 1'b1;
    dbg_bus.dbg_we    = we;
    dbg_bus.dbg_addr  = addr;
    dbg_bus.dbg_wdata = wdata;
    while (cyc < 30 && ack_cyc < 0) begin
      if (cyc > 0) @(negedge clk);
      wb_we   = (cyc >= wb_from) && (cyc < wb_from + wb_len);
      wb_addr = wa;
      wb_data = wd;
      #1;
      if (stall_o) begin
        stall_n++;
        if (first_stall < 0) first_stall = cyc;
      end
      if (wb_we && rf_we3 && rf_a3 == wa && rf_wd3 == wd) wb_hits++;
      if (rf_we3 && rf_a3 == addr && rf_wd3 == wdata) commit_cyc = cyc;
      if (rf_we3 && !wb_we) dbg_pulses++;
      if (dbg_bus.dbg_ack) begin
        ack_cyc = cyc;
        rdata = dbg_bus.dbg_rdata;
        dbg_bus.dbg_req = 1'b0;
      end
      cyc++;
    end
    wb_we = 1'b0;
    dbg_bus.dbg_req = 1'b0;
  endtask

  initial begin
    int n, ob, ack_c, st_n, st_f, com_c, wbh, dbp, acks, x4w;
    logic [31:0] rd;
    n_total = 0;
    n_bad = 0;
    rst = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    dbg_bus.dbg_req = 1'b0; dbg_bus.dbg_we = 1'b0;
    dbg_bus.dbg_addr = 5'd0; dbg_bus.dbg_wdata = 32'h0;

    // reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_stall", 32'(stall_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_we3", 32'(rf_we3), 32'd0);
    check("rst_ack", 32'(dbg_bus.dbg_ack), 32'd0);
    check("rst_rdata", dbg_bus.dbg_rdata, 32'h0);

    // init sweep
    @(negedge clk);
    rst = 1'b1;
    #1;
    sweep_run(n, ob);
    check("sweep_len", 32'(n), 32'd31);
    check("sweep_order", 32'(ob), 32'd0);
    check("sweep_idle", 32'(state_dbg), 32'd1);
    check("sweep_stall", 32'(stall_o), 32'd0);
    check("x0_kept", rf_m[0], 32'h0);
    check("x1_init", rf_m[1], 32'hDEAD_0000);
    check("x31_init", rf_m[31], 32'hDEAD_0000);

    // writeback pass-through, and a writeback to x0 never asserts rf_we3
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h8;
    #1;
    check("wb_pass_we", 32'(rf_we3), 32'd1);
    check("wb_pass_a3", 32'(rf_a3), 32'd5);
    @(negedge clk);
    wb_addr = 5'd0; wb_data = 32'h77;
    #1;
    check("wb_x0_we", 32'(rf_we3), 32'd0);
    @(negedge clk);
    wb_we = 1'b0;

    // debug read of x5
    dbg_txn(1'b0, 5'd5, 32'h0, 99, 0, 5'd0, 32'h0, ack_c, rd, st_n, st_f, com_c, wbh, dbp);
    check("rd5_ack_lat", 32'(ack_c), 32'd2);
    check("rd5_data", rd, 32'h8);
    check("rd5_stall_n", 32'(st_n), 32'd1);
    check("rd5_stall_at", 32'(st_f), 32'd1);

    // read bypass: writeback to x7 in the DBG_RD cycle
    @(negedge clk);
    dbg_txn(1'b0, 5'd7, 32'h0, 1, 1, 5'd7, 32'h1234, ack_c, rd, st_n, st_f, com_c, wbh, dbp);
    check("byp_ack_lat", 32'(ack_c), 32'd2);
    check("byp_data", rd, 32'h1234);
    check("byp_x7", rf_m[7], 32'h1234);

    // uncontended write of x10
    @(negedge clk);
    dbg_txn(1'b1, 5'd10, 32'hABCD, 99, 0, 5'd0, 32'h0, ack_c, rd, st_n, st_f, com_c, wbh, dbp);
    check("wr10_ack_lat", 32'(ack_c), 32'd2);
    check("wr10_commit", 32'(com_c), 32'd1);
    check("wr10_stall_n", 32'(st_n), 32'd0);
    check("wr10_x10", rf_m[10], 32'hABCD);

    // contended write of x3 against six writeback cycles to x9
    @(negedge clk);
    dbg_txn(1'b1, 5'd3, 32'hCAFE, 0, 6, 5'd9, 32'h99, ack_c, rd, st_n, st_f, com_c, wbh, dbp);
    check("cont_wb_hits", 32'(wbh), 32'd6);
    check("cont_stall_at", 32'(st_f), 32'd5);
    check("cont_stall_n", 32'(st_n), 32'd2);
    check("cont_commit", 32'(com_c), 32'd6);
    check("cont_ack", 32'(ack_c), 32'd7);
    check("cont_x9", rf_m[9], 32'h99);
    @(negedge clk);
    dbg_txn(1'b0, 5'd3, 32'h0, 99, 0, 5'd0, 32'h0, ack_c, rd, st_n, st_f, com_c, wbh, dbp);
    check("cont_rd3", rd, 32'hCAFE);

    // x0 write is acked with no write; x0 reads as zero
    @(negedge clk);
    dbg_txn(1'b1, 5'd0, 32'hFFFF_FFFF, 99, 0, 5'd0, 32'h0, ack_c, rd, st_n, st_f, com_c, wbh, dbp);
    check("x0w_ack", 32'(ack_c), 32'd2);
    check("x0w_pulses", 32'(dbp), 32'd0);
    @(negedge clk);
    dbg_txn(1'b0, 5'd0, 32'h0, 99, 0, 5'd0, 32'h0, ack_c, rd, st_n, st_f, com_c, wbh, dbp);
    check("x0r_ack", 32'(ack_c), 32'd2);
    check("x0r_data", rd, 32'h0);

    // reset while a debug write is parked behind writeback
    @(negedge clk);
    dbg_bus.dbg_req = 1'b1; dbg_bus.dbg_we = 1'b1;
    dbg_bus.dbg_addr = 5'd4; dbg_bus.dbg_wdata = 32'h5555;
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h77;
    acks = 0; x4w = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (dbg_bus.dbg_ack) acks++;
      if (rf_we3 && rf_a3 == 5'd4) x4w++;
    end
    check("mid_state_wr", 32'(state_dbg), 32'd3);
    rst = 1'b0;
    dbg_bus.dbg_req = 1'b0;
    wb_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      if (dbg_bus.dbg_ack) acks++;
      if (rf_we3 && rf_a3 == 5'd4) x4w++;
    end
    check("mid_rst_stall", 32'(stall_o), 32'd1);
    check("mid_rst_a2sel", 32'(rf_a2_sel), 32'd0);
    check("mid_no_ack", 32'(acks), 32'd0);
    check("mid_no_x4_wr", 32'(x4w), 32'd0);
    check("mid_x4", rf_m[4], 32'hDEAD_0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("resweep_a3", 32'(rf_a3), 32'd1);
    sweep_run(n, ob);
    check("resweep_len", 32'(n), 32'd31);
    check("resweep_order", 32'(ob), 32'd0);
    check("resweep_x3", rf_m[3], 32'hDEAD_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Owns the write port and the second read port of the 32x32 integer register file in the pipelined RV32I core.
- After reset it sweeps x1..x31 to a known value.
- It then passes pipeline writeback through to the write port, and slots debug-port read and write requests into the register file without corrupting pipeline state.
- Sits between the WB stage, the debug requester, and the register file write port and A2/RD2 path.

Parameters:
- ENABLE_INIT, 1: 1 means sweep registers after reset; 0 means go directly to IDLE.
- INIT_VAL, 32'h00000000: value written to x1..x31 during the sweep.
- MAX_WAIT, 4: cycles a debug write defers to writeback before stall_o is forced.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- wb_we  in  1  pipeline writeback enable.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- dbg_req  in  1  debug request; held high until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read; stable while dbg_req is high.
- dbg_addr  in  5  debug register index; stable while dbg_req is high.
- dbg_wdata  in  32  debug write data; stable while dbg_req is high.
- dbg_ack  out  1  one-cycle completion pulse, registered.
- dbg_rdata  out  32  read result, registered, valid from the dbg_ack cycle until the next ack.
- rf_we3  out  1  register file write enable.
- rf_a3  out  5  register file write address.
- rf_wd3  out  32  register file write data.
- rf_a2_sel  out  1  1 = A2 driven by rf_a2_dbg instead of decode.
- rf_a2_dbg  out  5  debug read address for A2.
- rf_rd2  in  32  register file RD2 (combinational read).
- stall_o  out  1  freeze the IF..MEM stages; WB drains.
- busy  out  1  high while the init sweep runs.

Behaviour:
- Reset (rst==0 at posedge):
  - state goes to INIT (or IDLE if ENABLE_INIT=0); cnt <= 1.
  - dbg_ack <= 0 and dbg_rdata <= 0.
  - While rst is low, rf_we3=0 and rf_a2_sel=0; stall_o=1 and busy=1.
  - Reset mid-transaction abandons it with no ack.
- INIT:
  - Outputs: rf_we3=1, rf_a3=cnt, rf_wd3=INIT_VAL, stall_o=1, busy=1.
  - wb_we and dbg_req are ignored.
  - cnt increments each cycle; the cycle with cnt==31 is the last, then IDLE.
  - Exactly 31 write cycles; x0 is never written.
- Write port mux:
  - rf_we3/rf_a3/rf_wd3 = wb_* in every state except INIT and the DBG_WR commit cycle.
  - Writeback always has priority.
- IDLE:
  - stall_o=0, rf_a2_sel=0.
  - If dbg_req=1: go to DBG_RD when dbg_we=0, or to DBG_WR when dbg_we=1 (waitcnt <= 0).
- DBG_RD (exactly 1 cycle):
  - Outputs: stall_o=1, rf_a2_sel=1, rf_a2_dbg=dbg_addr.
  - dbg_rdata <= 0 if dbg_addr==0.
  - Otherwise dbg_rdata <= wb_data if wb_we && wb_addr==dbg_addr (write-bypass).
  - Otherwise dbg_rdata <= rf_rd2.
  - Next state: ACK.
- DBG_WR:
  - Port is busy when wb_we && wb_addr!=0. While busy: stay, waitcnt++.
  - When waitcnt >= MAX_WAIT: stall_o=1 (the pipeline guarantees wb_we drops within the drain).
  - When the port is free, this is the commit cycle: rf_we3=(dbg_addr!=0), rf_a3=dbg_addr, rf_wd3=dbg_wdata. Next state: ACK.
  - A write to x0 is acked with no write.
- ACK (1 cycle):
  - dbg_ack=1, stall_o=0; next state IDLE.
  - The requester drops dbg_req in the ack cycle. dbg_req high in the following IDLE cycle is a new request.
- Latency:
  - Read: request seen in IDLE at cycle N, ack at N+2.
  - Uncontended write: ack at N+2, write committed at N+1.
- Free-running invariants:
  - dbg_ack is never high for two consecutive cycles.
  - rf_we3 is never high with rf_a3==0.

Test Plan:
- Sweep: rst low 2 cycles, then high, ENABLE_INIT=1, INIT_VAL=32'hDEAD0000 → busy high for exactly 31 cycles; writes to x1..x31 in order; x0 stays 0; busy falls; IDLE.
- Debug read: after init, wb writes x5=32'h8; dbg read x5 → stall_o high 1 cycle; ack 2 cycles after the request; dbg_rdata=32'h8.
- Read bypass: dbg read x7 in the same cycle WB writes x7=32'h1234 → dbg_rdata=32'h1234, not the old value.
- Write contention: dbg write x3=32'hCAFE while wb_we=1 to x9 for 6 consecutive cycles (MAX_WAIT=4) → WB writes all land; stall_o rises after 4 wait cycles; debug write commits in the first cycle wb_we=0; ack follows; x3 reads back 32'hCAFE.
- x0 handling: dbg write x0=32'hFFFF_FFFF → ack with no rf_we3 pulse; subsequent dbg read x0 → 0.
- Reset mid-op: rst low during DBG_WR → no ack, no debug write; INIT sweep restarts from x1.
